// File: rtl/seg_scan_driver.sv
// ---------------------------------------------------------------------------
// seg_scan_driver
//
// Purpose:
//   Drives two 4-digit seven-segment banks from a 32-bit hex value plus eight
//   decimal-point bits. The digits are time-multiplexed: each scan step lights
//   one digit in each bank. New values are loaded into a pending register.
//   They are copied to the displayed (shadow) copy only when the scan wraps
//   from digit 3 back to digit 0, so a frame never shows a mix of old and new
//   digits.
//
// Parameters:
//   CLK_DIV     clk cycles per scan step (2 .. 2^20)
//
// Ports:
//   clk         system clock
//   rst         asynchronous, active-high reset
//   data[31:0]  hex value, digit k = data[4k+3:4k], digit 7 is leftmost
//   dp[7:0]     decimal-point enables, dp[k] belongs to digit k
//   load        one-cycle strobe, captures data/dp into the pending register
//   blank       level, forces seg_code_0/seg_code_1/pos to 0 from next edge
//   seg_code_0  segments {dp,g,f,e,d,c,b,a} for digits 3..0 (active-high)
//   seg_code_1  segments for digits 7..4, same encoding
//   pos         digit enables, pos[k] enables digit k (two bits set)
//   frame       one-cycle pulse after the scan index wraps 3->0
//
// Build option:
//   SEG_LEADING_ZERO_SUPPRESS_EN - when defined, leading zero digits (from
//   digit 7 downwards) are shown fully dark, including their dp bit. Digit 0
//   is always shown. When undefined, every digit shows its glyph.
// ---------------------------------------------------------------------------
module seg_scan_driver #(
  parameter int unsigned CLK_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data,
  input  logic [7:0]  dp,
  input  logic        load,
  input  logic        blank,
  output logic [7:0]  seg_code_0,
  output logic [7:0]  seg_code_1,
  output logic [7:0]  pos,
  output logic        frame
);

  localparam int unsigned   CW   = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  // Hex font, bits {g,f,e,d,c,b,a}
  function automatic logic [6:0] font7(input logic [3:0] n);
    logic [6:0] f;
    case (n)
      4'h0: f = 7'h3F;
      4'h1: f = 7'h06;
      4'h2: f = 7'h5B;
      4'h3: f = 7'h4F;
      4'h4: f = 7'h66;
      4'h5: f = 7'h6D;
      4'h6: f = 7'h7D;
      4'h7: f = 7'h07;
      4'h8: f = 7'h7F;
      4'h9: f = 7'h6F;
      4'hA: f = 7'h77;
      4'hB: f = 7'h7C;
      4'hC: f = 7'h39;
      4'hD: f = 7'h5E;
      4'hE: f = 7'h79;
      default: f = 7'h71;
    endcase
    return f;
  endfunction

  // Scan state
  logic [CW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;

  // Pending / shadow copies of the display value
  logic [31:0]   pend_data_q, pend_data_d;
  logic [7:0]    pend_dp_q, pend_dp_d;
  logic          pend_valid_q, pend_valid_d;
  logic [31:0]   shadow_data_q, shadow_data_d;
  logic [7:0]    shadow_dp_q, shadow_dp_d;

  // Registered outputs
  logic [7:0]    seg0_q, seg0_d;
  logic [7:0]    seg1_q, seg1_d;
  logic [7:0]    pos_q, pos_d;
  logic          frame_q, frame_d;

  logic          tick;
  logic          commit;
  logic [7:0]    glyph [8];
  logic [3:0]    onehot;

  assign tick   = (presc_q == LAST);
  // The only point where the displayed value may change: the step that
  // leaves digit 3 and starts a new frame at digit 0.
  assign commit = tick && (idx_q == 2'd3);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q       <= '0;
      idx_q         <= '0;
      pend_data_q   <= '0;
      pend_dp_q     <= '0;
      pend_valid_q  <= 1'b0;
      shadow_data_q <= '0;
      shadow_dp_q   <= '0;
      seg0_q        <= '0;
      seg1_q        <= '0;
      pos_q         <= '0;
      frame_q       <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      idx_q         <= idx_d;
      pend_data_q   <= pend_data_d;
      pend_dp_q     <= pend_dp_d;
      pend_valid_q  <= pend_valid_d;
      shadow_data_q <= shadow_data_d;
      shadow_dp_q   <= shadow_dp_d;
      seg0_q        <= seg0_d;
      seg1_q        <= seg1_d;
      pos_q         <= pos_d;
      frame_q       <= frame_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    presc_d       = tick ? '0 : presc_q + CW'(1);
    idx_d         = tick ? idx_q + 2'd1 : idx_q;
    pend_data_d   = pend_data_q;
    pend_dp_d     = pend_dp_q;
    pend_valid_d  = pend_valid_q;
    shadow_data_d = shadow_data_q;
    shadow_dp_d   = shadow_dp_q;

    // Commit uses the pending value from before this edge; a load arriving
    // on the commit edge therefore waits for the following frame.
    if (commit && pend_valid_q) begin
      shadow_data_d = pend_data_q;
      shadow_dp_d   = pend_dp_q;
      pend_valid_d  = 1'b0;
    end
    if (load) begin
      pend_data_d  = data;
      pend_dp_d    = dp;
      pend_valid_d = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Per-digit glyphs from the shadow copy
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_digit
      logic [3:0] nib;
      logic       hide;
      assign nib = shadow_data_q[4*gi +: 4];
`ifdef SEG_LEADING_ZERO_SUPPRESS_EN
      if (gi == 0) begin : g_first
        assign hide = 1'b0;
      end else begin : g_rest
        // Dark when this digit and every digit to its left are zero.
        assign hide = (shadow_data_q[31:4*gi] == '0);
      end
`else
      assign hide = 1'b0;
`endif
      assign glyph[gi] = hide ? 8'h00 : {shadow_dp_q[gi], font7(nib)};
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Output logic (registered one cycle later)
  // -------------------------------------------------------------------------
  always_comb begin
    onehot  = 4'b0001 << idx_q;
    seg0_d  = glyph[{1'b0, idx_q}];
    seg1_d  = glyph[{1'b1, idx_q}];
    pos_d   = {onehot, onehot};
    frame_d = commit;
    if (blank) begin
      seg0_d = '0;
      seg1_d = '0;
      pos_d  = '0;
    end
  end

  assign seg_code_0 = seg0_q;
  assign seg_code_1 = seg1_q;
  assign pos        = pos_q;
  assign frame      = frame_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// ---------------------------------------------------------------------------
// Testbench for seg_scan_driver (CLK_DIV = 4).
// The reference model works on the edge count since reset: the scan index
// before edge e is ((e-1)/D)%4, and a frame boundary (commit) is any edge
// with e % (4*D) == 0.
// ---------------------------------------------------------------------------
module tb_seg_scan_driver;

  localparam int D = 4;
  localparam int FR = 4 * D;

`ifdef SEG_LEADING_ZERO_SUPPRESS_EN
  localparam logic [7:0] SZ   = 8'h00;  // zero digit other than digit 0
  localparam logic [7:0] DP7X = 8'h00;  // digit 7 of value 0 with dp set
`else
  localparam logic [7:0] SZ   = 8'h3F;
  localparam logic [7:0] DP7X = 8'hBF;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data;
  logic [7:0]  dp;
  logic        load;
  logic        blank;
  logic [7:0]  seg_code_0, seg_code_1, pos;
  logic        frame;

  always #5 clk = ~clk;

  seg_scan_driver #(.CLK_DIV(D)) dut (
    .clk(clk), .rst(rst), .data(data), .dp(dp), .load(load), .blank(blank),
    .seg_code_0(seg_code_0), .seg_code_1(seg_code_1), .pos(pos), .frame(frame)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int          e;
  logic [31:0] m_pd, m_sd;
  logic [7:0]  m_pp, m_sp;
  bit          m_v;
  int          m_k;
  logic [7:0]  e_pos, e_s0, e_s1;
  logic        e_fr;

  logic [6:0] font_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  function automatic logic [7:0] glyph(input logic [31:0] d, input logic [7:0] p, input int k);
    logic [3:0] n;
    n = 4'((d >> (4 * k)) & 32'hF);
`ifdef SEG_LEADING_ZERO_SUPPRESS_EN
    if (k > 0 && (d >> (4 * k)) == 32'd0) return 8'h00;
`endif
    return {p[k], font_tab[n]};
  endfunction

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h (edge %0d)", name, act, exp, e);
    end
  endtask

  task automatic model_reset();
    e = 0; m_pd = '0; m_sd = '0; m_pp = '0; m_sp = '0; m_v = 0;
  endtask

  // One clock: drive inputs, advance the model across the edge, compare at +1.
  task automatic step(input logic ld, input logic [31:0] d, input logic [7:0] p,
                      input logic bl, input bit chk);
    load = ld; data = d; dp = p; blank = bl;
    @(posedge clk);
    e++;
    m_k   = ((e - 1) / D) % 4;
    e_pos = bl ? 8'h00 : 8'((1 << m_k) | (1 << (m_k + 4)));
    e_s0  = bl ? 8'h00 : glyph(m_sd, m_sp, m_k);
    e_s1  = bl ? 8'h00 : glyph(m_sd, m_sp, m_k + 4);
    e_fr  = (e % FR == 0);
    if (e_fr && m_v) begin m_sd = m_pd; m_sp = m_pp; m_v = 0; end
    if (ld) begin m_pd = d; m_pp = p; m_v = 1; end
    #1;
    if (chk) begin
      check8("pos", pos, e_pos);
      check8("seg0", seg_code_0, e_s0);
      check8("seg1", seg_code_1, e_s1);
      check8("frame", {7'd0, frame}, {7'd0, e_fr});
    end
    $display("edge %0d ld=%0b bl=%0b pos=%02h seg0=%02h seg1=%02h frame=%0b",
             e, ld, bl, pos, seg_code_0, seg_code_1, frame);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, 8'd0, 1'b0, 1'b1);
  endtask

  // Step until the model edge count satisfies e % FR == target (bounded).
  task automatic align(input int target);
    for (int i = 0; i < FR && (e % FR) != target; i++) step(1'b0, 32'd0, 8'd0, 1'b0, 1'b1);
  endtask

  task automatic check_zero(input string tag);
    check8({tag, "_pos"}, pos, 8'h00);
    check8({tag, "_seg0"}, seg_code_0, 8'h00);
    check8({tag, "_seg1"}, seg_code_1, 8'h00);
    check8({tag, "_frame"}, {7'd0, frame}, 8'h00);
  endtask

  typedef struct {
    logic       bl;
    logic [7:0] pos;
    logic [7:0] s0;
    logic [7:0] s1;
    logic       fr;
  } vec_t;

  vec_t tbl [17];
  int   cnt;
  logic bl_state;

  initial begin
    // Idle scan after reset, shadow = 0; edges 9 and 10 blanked.
    tbl = '{
      '{1'b0, 8'h11, 8'h3F, SZ, 1'b0}, '{1'b0, 8'h11, 8'h3F, SZ, 1'b0},
      '{1'b0, 8'h11, 8'h3F, SZ, 1'b0}, '{1'b0, 8'h11, 8'h3F, SZ, 1'b0},
      '{1'b0, 8'h22, SZ,    SZ, 1'b0}, '{1'b0, 8'h22, SZ,    SZ, 1'b0},
      '{1'b0, 8'h22, SZ,    SZ, 1'b0}, '{1'b0, 8'h22, SZ,    SZ, 1'b0},
      '{1'b1, 8'h00, 8'h00, 8'h00, 1'b0}, '{1'b1, 8'h00, 8'h00, 8'h00, 1'b0},
      '{1'b0, 8'h44, SZ,    SZ, 1'b0}, '{1'b0, 8'h44, SZ,    SZ, 1'b0},
      '{1'b0, 8'h88, SZ,    SZ, 1'b0}, '{1'b0, 8'h88, SZ,    SZ, 1'b0},
      '{1'b0, 8'h88, SZ,    SZ, 1'b0}, '{1'b0, 8'h88, SZ,    SZ, 1'b1},
      '{1'b0, 8'h11, 8'h3F, SZ, 1'b0}
    };

    rst = 1'b1; load = 1'b0; data = '0; dp = '0; blank = 1'b0;
    model_reset();
    #12;
    check_zero("reset");
    rst = 1'b0;

    // Table-driven idle scan
    for (int i = 0; i < 17; i++) begin
      step(1'b0, 32'd0, 8'd0, tbl[i].bl, 1'b0);
      check8($sformatf("tbl%0d_pos", i), pos, tbl[i].pos);
      check8($sformatf("tbl%0d_seg0", i), seg_code_0, tbl[i].s0);
      check8($sformatf("tbl%0d_seg1", i), seg_code_1, tbl[i].s1);
      check8($sformatf("tbl%0d_frame", i), {7'd0, frame}, {7'd0, tbl[i].fr});
    end

    // Load at idx=1, commit on the wrap, then known glyphs
    align(5);
    step(1'b1, 32'h89AB_CDEF, 8'h00, 1'b0, 1'b1);
    align(0);
    for (int i = 0; i < FR; i++) begin
      step(1'b0, 32'd0, 8'd0, 1'b0, 1'b1);
      if (m_k == 0) begin
        check8("lc_d0", seg_code_0, 8'h71);
        check8("lc_d4", seg_code_1, 8'h7C);
      end
      if (m_k == 3) begin
        check8("lc_d3", seg_code_0, 8'h39);
        check8("lc_d7", seg_code_1, 8'h7F);
      end
    end

    // Two loads in one frame: only the last one is ever shown
    cnt = 0;
    align(0);
    step(1'b1, 32'h1111_1111, 8'h00, 1'b0, 1'b1);
    idle(3);
    step(1'b1, 32'h2222_2222, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 2 * FR; i++) begin
      step(1'b0, 32'd0, 8'd0, 1'b0, 1'b1);
      if (seg_code_0 == 8'h06 || seg_code_1 == 8'h06) cnt++;
    end
    check8("dbl_no06", 8'(cnt), 8'h00);
    check8("dbl_seg0", seg_code_0, 8'h5B);

    // Decimal point on digit 7, then blank
    align(0);
    step(1'b1, 32'h0000_0000, 8'h80, 1'b0, 1'b1);
    align(0);
    for (int i = 0; i < FR; i++) begin
      step(1'b0, 32'd0, 8'd0, 1'b0, 1'b1);
      if (m_k == 3) check8("dp7_seg1", seg_code_1, DP7X);
    end
    cnt = 0;
    for (int i = 0; i < 2 * FR + 1; i++) begin
      step(1'b0, 32'd0, 8'd0, 1'b1, 1'b1);
      if (frame) cnt++;
    end
    check8("blank_frames", 8'(cnt), 8'd2);
    idle(8);

    // Load exactly on the commit edge: held back one frame
    align(FR - 1);
    step(1'b1, 32'h0000_0005, 8'h00, 1'b0, 1'b1);
    for (int i = 1; i <= 2 * FR; i++) begin
      step(1'b0, 32'd0, 8'd0, 1'b0, 1'b1);
      if (i == 1) check8("cmt_old_d0", seg_code_0, 8'h3F);
      if (i == FR + 1) check8("cmt_new_d0", seg_code_0, 8'h6D);
    end

`ifdef SEG_LEADING_ZERO_SUPPRESS_EN
    align(0);
    step(1'b1, 32'h0000_0A05, 8'h00, 1'b0, 1'b1);
    align(0);
    for (int i = 0; i < FR; i++) begin
      step(1'b0, 32'd0, 8'd0, 1'b0, 1'b1);
      check8("lzs_seg1", seg_code_1, 8'h00);
      case (m_k)
        0: check8("lzs_d0", seg_code_0, 8'h6D);
        1: check8("lzs_d1", seg_code_0, 8'h3F);
        2: check8("lzs_d2", seg_code_0, 8'h77);
        default: check8("lzs_d3", seg_code_0, 8'h00);
      endcase
    end
`endif

    // Randomized traffic against the model
    bl_state = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) bl_state = ~bl_state;
      step(($urandom_range(0, 7) == 0), $urandom, 8'($urandom), bl_state, 1'b1);
    end
    idle(2 * FR);

    // Asynchronous reset mid-frame with a load still pending
    align(2);
    step(1'b1, 32'hDEAD_BEEF, 8'hFF, 1'b0, 1'b1);
    idle(2);
    #2 rst = 1'b1;
    #1 check_zero("async_rst");
    @(posedge clk);
    #1 check_zero("rst_hold");
    #1 rst = 1'b0;
    model_reset();
    idle(2 * FR + 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
